// File: rtl/dest_tag_pipe_pkg.sv
// Shared widths for the dual-lane destination-tag pipeline.
// A tag bundle is {rd, regwrite, memread}.
package dest_tag_pipe_pkg;

  localparam int DEF_AWIDTH = 5;
  localparam int NUM_LANES  = 2;
  localparam int TAG_WIDTH  = DEF_AWIDTH + 2;

  function automatic int tag_width(input int awidth);
    return awidth + 2;
  endfunction

endpackage

// File: rtl/dest_tag_pipe_stage.sv
// One lane, one pipeline stage of the destination tag.
// A synchronous bubble loads an all-zero tag.
import dest_tag_pipe_pkg::*;

module dest_tag_stage #(
  parameter int AWIDTH = DEF_AWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bubble,
  input  logic [AWIDTH-1:0] d_rd,
  input  logic              d_regwrite,
  input  logic              d_memread,
  output logic [AWIDTH-1:0] q_rd,
  output logic              q_regwrite,
  output logic              q_memread
);

  localparam int TW = tag_width(AWIDTH);

  logic [TW-1:0] tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag <= '0;
    end else if (bubble) begin
      tag <= '0;
    end else begin
      tag <= {d_rd, d_regwrite, d_memread};
    end
  end

  assign q_rd       = tag[TW-1:2];
  assign q_regwrite = tag[1];
  assign q_memread  = tag[0];

endmodule

// File: rtl/dest_tag_pipe.sv
// Producer side of the dual-issue forwarding interface: qualifies decode
// tags, resolves same-pair WAW, carries tags through EX and WB, counts stalls.
import dest_tag_pipe_pkg::*;

module dest_tag_pipe #(
  parameter int AWIDTH = DEF_AWIDTH,
  parameter int CWIDTH = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [1:0]        ds_i_valid,
  input  logic [AWIDTH-1:0] ds_i_addr_rd0,
  input  logic [AWIDTH-1:0] ds_i_addr_rd1,
  input  logic [1:0]        ds_i_regwrite,
  input  logic [1:0]        ds_i_memread,
  input  logic              i_stall,
  input  logic              i_flush,
  output logic [AWIDTH-1:0] ex_o_addr_rd0,
  output logic [AWIDTH-1:0] ex_o_addr_rd1,
  output logic [1:0]        ex_o_regwrite,
  output logic [1:0]        ex_o_memread,
  output logic [AWIDTH-1:0] wb_o_addr_rd0,
  output logic [AWIDTH-1:0] wb_o_addr_rd1,
  output logic [1:0]        wb_o_regwrite,
  output logic [CWIDTH-1:0] o_stall_cnt
);

  logic [AWIDTH-1:0]    ds_rd [NUM_LANES];
  logic [AWIDTH-1:0]    ex_rd [NUM_LANES];
  logic [AWIDTH-1:0]    wb_rd [NUM_LANES];
  logic [NUM_LANES-1:0] rw_eff;
  logic [NUM_LANES-1:0] rw_cap;
  logic [NUM_LANES-1:0] mr_cap;
  logic [NUM_LANES-1:0] wb_memread_unused;
  logic                 waw;
  logic                 ex_bubble;
  logic [CWIDTH-1:0]    stall_cnt;

  assign ds_rd[0] = ds_i_addr_rd0;
  assign ds_rd[1] = ds_i_addr_rd1;

  always_comb begin
    rw_eff[0] = ds_i_valid[0] & ds_i_regwrite[0] & (ds_i_addr_rd0 != '0);
    rw_eff[1] = ds_i_valid[1] & ds_i_regwrite[1] & (ds_i_addr_rd1 != '0);
    // Younger lane 1 wins a same-pair write to the same register.
    waw       = rw_eff[0] & rw_eff[1] & (ds_i_addr_rd0 == ds_i_addr_rd1);
    rw_cap    = rw_eff & ~{1'b0, waw};
    mr_cap    = ds_i_valid & ds_i_memread & rw_cap;
  end

  assign ex_bubble = i_stall | i_flush;

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    dest_tag_stage #(.AWIDTH(AWIDTH)) u_ex (
      .clk        (i_clk),
      .rst_n      (i_rst_n),
      .bubble     (ex_bubble),
      .d_rd       (ds_rd[n]),
      .d_regwrite (rw_cap[n]),
      .d_memread  (mr_cap[n]),
      .q_rd       (ex_rd[n]),
      .q_regwrite (ex_o_regwrite[n]),
      .q_memread  (ex_o_memread[n])
    );

    // WB never freezes or clears; memread is not carried past EX.
    dest_tag_stage #(.AWIDTH(AWIDTH)) u_wb (
      .clk        (i_clk),
      .rst_n      (i_rst_n),
      .bubble     (1'b0),
      .d_rd       (ex_rd[n]),
      .d_regwrite (ex_o_regwrite[n]),
      .d_memread  (1'b0),
      .q_rd       (wb_rd[n]),
      .q_regwrite (wb_o_regwrite[n]),
      .q_memread  (wb_memread_unused[n])
    );
  end

  assign ex_o_addr_rd0 = ex_rd[0];
  assign ex_o_addr_rd1 = ex_rd[1];
  assign wb_o_addr_rd0 = wb_rd[0];
  assign wb_o_addr_rd1 = wb_rd[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt <= '0;
    end else if (i_stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CWIDTH'(1);
    end
  end

  assign o_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_dest_tag_pipe.sv
// Self-checking bench for dest_tag_pipe: vector table with EX scoreboard,
// plus hand sequences for reset mid-flight and counter saturation.
module tb_dest_tag_pipe;

  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    valid = '0;
  logic [AW-1:0] rd0 = '0, rd1 = '0;
  logic [1:0]    rw = '0, mr = '0;
  logic          stall = 1'b0, flush = 1'b0;
  logic [AW-1:0] ex_rd0, ex_rd1, wb_rd0, wb_rd1;
  logic [1:0]    ex_rw, ex_mr, wb_rw;
  logic [CW-1:0] cnt;

  int tests = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]    valid;
    logic [AW-1:0] rd0, rd1;
    logic [1:0]    rw, mr;
    logic          stall, flush;
    logic [AW-1:0] e_rd0, e_rd1;
    logic [1:0]    e_rw, e_mr;
  } vec_t;

  typedef struct {
    logic [AW-1:0] rd0, rd1;
    logic [1:0]    rw, mr;
  } tag_t;

  vec_t vecs[$];
  tag_t sb[$];
  tag_t wb_exp;
  int   cnt_exp;
  logic stall_applied;

  dest_tag_pipe #(.AWIDTH(AW), .CWIDTH(CW)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .ds_i_valid    (valid),
    .ds_i_addr_rd0 (rd0),
    .ds_i_addr_rd1 (rd1),
    .ds_i_regwrite (rw),
    .ds_i_memread  (mr),
    .i_stall       (stall),
    .i_flush       (flush),
    .ex_o_addr_rd0 (ex_rd0),
    .ex_o_addr_rd1 (ex_rd1),
    .ex_o_regwrite (ex_rw),
    .ex_o_memread  (ex_mr),
    .wb_o_addr_rd0 (wb_rd0),
    .wb_o_addr_rd1 (wb_rd1),
    .wb_o_regwrite (wb_rw),
    .o_stall_cnt   (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    tag_t t;
    valid = v.valid; rd0 = v.rd0; rd1 = v.rd1;
    rw = v.rw; mr = v.mr; stall = v.stall; flush = v.flush;
    t.rd0 = v.e_rd0; t.rd1 = v.e_rd1; t.rw = v.e_rw; t.mr = v.e_mr;
    sb.push_back(t);
  endtask

  // Advance one edge, then compare EX against the scoreboard and WB
  // against the EX expectation of the previous cycle.
  task automatic step_check(input string tag);
    tag_t e;
    stall_applied = stall;
    @(posedge clk);
    if (stall_applied && cnt_exp < (1 << CW) - 1) cnt_exp++;
    #1;
    if (sb.size() == 0) begin
      chk({tag, " sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({tag, " ex_rd0"}, int'(ex_rd0), int'(e.rd0));
    chk({tag, " ex_rd1"}, int'(ex_rd1), int'(e.rd1));
    chk({tag, " ex_rw"},  int'(ex_rw),  int'(e.rw));
    chk({tag, " ex_mr"},  int'(ex_mr),  int'(e.mr));
    chk({tag, " wb_rd0"}, int'(wb_rd0), int'(wb_exp.rd0));
    chk({tag, " wb_rd1"}, int'(wb_rd1), int'(wb_exp.rd1));
    chk({tag, " wb_rw"},  int'(wb_rw),  int'(wb_exp.rw));
    chk({tag, " cnt"},    int'(cnt),    cnt_exp);
    wb_exp = e;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " ex_rd0"}, int'(ex_rd0), 0);
    chk({tag, " ex_rd1"}, int'(ex_rd1), 0);
    chk({tag, " ex_rw"},  int'(ex_rw),  0);
    chk({tag, " ex_mr"},  int'(ex_mr),  0);
    chk({tag, " wb_rd0"}, int'(wb_rd0), 0);
    chk({tag, " wb_rd1"}, int'(wb_rd1), 0);
    chk({tag, " wb_rw"},  int'(wb_rw),  0);
    chk({tag, " cnt"},    int'(cnt),    0);
  endtask

  initial begin
    vec_t v;
    //                valid  rd0 rd1 rw     mr     st    fl    erd0 erd1 erw    emr
    vecs.push_back('{2'b11,  5,  7, 2'b11, 2'b00, 1'b0, 1'b0,  5,  7, 2'b11, 2'b00}); // advance
    vecs.push_back('{2'b01,  9,  3, 2'b01, 2'b01, 1'b0, 1'b0,  9,  3, 2'b01, 2'b01}); // load rd9
    vecs.push_back('{2'b11,  2,  4, 2'b11, 2'b00, 1'b1, 1'b0,  0,  0, 2'b00, 2'b00}); // load-use
    vecs.push_back('{2'b11,  0,  6, 2'b11, 2'b00, 1'b0, 1'b0,  0,  6, 2'b10, 2'b00}); // x0
    vecs.push_back('{2'b11, 12, 12, 2'b11, 2'b11, 1'b0, 1'b0, 12, 12, 2'b10, 2'b10}); // WAW
    vecs.push_back('{2'b01,  3,  1, 2'b01, 2'b00, 1'b0, 1'b0,  3,  1, 2'b01, 2'b00}); // EX rd3
    vecs.push_back('{2'b11,  8, 10, 2'b11, 2'b01, 1'b0, 1'b1,  0,  0, 2'b00, 2'b00}); // flush
    vecs.push_back('{2'b11, 11, 13, 2'b11, 2'b00, 1'b1, 1'b1,  0,  0, 2'b00, 2'b00}); // flush+stall
    vecs.push_back('{2'b10,  4,  0, 2'b11, 2'b00, 1'b0, 1'b0,  4,  0, 2'b00, 2'b00}); // x0 lane1
    vecs.push_back('{2'b00,  1,  2, 2'b11, 2'b11, 1'b0, 1'b0,  1,  2, 2'b00, 2'b00}); // no issue
    vecs.push_back('{2'b11, 13, 14, 2'b00, 2'b11, 1'b0, 1'b0, 13, 14, 2'b00, 2'b00}); // mr no rw
    vecs.push_back('{2'b11, 15, 16, 2'b11, 2'b01, 1'b0, 1'b0, 15, 16, 2'b11, 2'b01}); // load lane0
    vecs.push_back('{2'b11,  7,  7, 2'b11, 2'b10, 1'b0, 1'b0,  7,  7, 2'b10, 2'b10}); // WAW load1

    wb_exp = '{default: '0};
    cnt_exp = 0;

    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      drive(vecs[i]);
      step_check($sformatf("vec%0d", i));
    end

    // Reset mid-flight: tags in EX and WB are non-zero when reset drops.
    v = vecs[0];
    drive(v);
    step_check("pre_rst");
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    sb.delete();
    wb_exp = '{default: '0};
    cnt_exp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    v = '{2'b11, 20, 21, 2'b11, 2'b00, 1'b0, 1'b0, 20, 21, 2'b11, 2'b00};
    drive(v);
    step_check("post_rst");

    // Counter saturation: 20 stall cycles on a 4-bit counter.
    v = '{2'b11, 5, 6, 2'b11, 2'b00, 1'b1, 1'b0, 0, 0, 2'b00, 2'b00};
    for (int k = 0; k < 20; k++) begin
      drive(v);
      step_check($sformatf("sat%0d", k));
    end
    chk("sat_final", int'(cnt), 15);
    v = '{2'b01, 9, 0, 2'b01, 2'b00, 1'b0, 1'b0, 9, 0, 2'b01, 2'b00};
    drive(v);
    step_check("sat_hold");

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: sim time %0t exceeded limit %0d", $time, 50000);
    $fatal(1, "timeout");
  end

endmodule
